// File: rtl/calc_e_sched.sv
// Scheduler that feeds candidate sequences to NUM_UNITS energy engines and tracks the minimum-energy result.
// Optional early stop on an energy threshold: define CALC_E_SCHED_THRESH_EN.
module calc_e_sched #(
  parameter int NUM_UNITS = 4,
  parameter int SEQ_WIDTH = 40,
  parameter int E_WIDTH   = 20,
  parameter int CNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNT_WIDTH-1:0]           cfg_count,
  input  logic [6:0]                     cfg_offset,
  input  logic [SEQ_WIDTH-1:0]           cfg_mask,
  input  logic [SEQ_WIDTH-1:0]           s_seq,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [SEQ_WIDTH-1:0]           eng_seq,
  output logic [NUM_UNITS-1:0]           eng_valid,
  input  logic [NUM_UNITS-1:0]           eng_ready,
  input  logic [NUM_UNITS*E_WIDTH-1:0]   res_e,
  input  logic [NUM_UNITS*SEQ_WIDTH-1:0] res_seq,
  input  logic [NUM_UNITS-1:0]           res_valid,
  output logic [NUM_UNITS-1:0]           res_ack,
  output logic [E_WIDTH-1:0]             best_e,
  output logic [SEQ_WIDTH-1:0]           best_seq,
  output logic [CNT_WIDTH-1:0]           n_done,
  output logic                           busy,
  output logic                           done
`ifdef CALC_E_SCHED_THRESH_EN
  ,
  input  logic [E_WIDTH-1:0]             cfg_thresh,
  output logic                           hit
`endif
);

  localparam int PTR_W = $clog2(NUM_UNITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [CNT_WIDTH-1:0]   issued_q, issued_d;
  logic [CNT_WIDTH-1:0]   n_done_q, n_done_d;
  logic [E_WIDTH-1:0]     best_e_q, best_e_d;
  logic [SEQ_WIDTH-1:0]   best_seq_q, best_seq_d;
  logic [NUM_UNITS-1:0]   eng_valid_q, eng_valid_d;
  logic [SEQ_WIDTH-1:0]   eng_seq_q, eng_seq_d;
  logic [NUM_UNITS-1:0]   res_ack_q, res_ack_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   hit_block;

  logic [NUM_UNITS-1:0]   disp_elig, col_elig;
  logic [PTR_W-1:0]       disp_idx, col_idx, cand;
  logic                   disp_ok, col_ok, col_found;
  logic [E_WIDTH-1:0]     col_e;
  logic [SEQ_WIDTH-1:0]   col_seq;

  // Offset and mask reach the engines by direct wiring in the parent; nothing here consumes them.
  logic unused_cfg;
  assign unused_cfg = ^{cfg_offset, cfg_mask};

`ifdef CALC_E_SCHED_THRESH_EN
  logic [E_WIDTH-1:0] thresh_q, thresh_d;
  logic               hit_q, hit_d;
  assign hit_block = hit_q;
  assign hit       = hit_q;
`else
  assign hit_block = 1'b0;
`endif

  // A unit strobed or acked last cycle still shows its stale registered ready/valid, so it is masked.
  assign disp_elig = eng_ready & ~eng_valid_q;
  assign col_elig  = res_valid & ~res_ack_q;

  assign disp_ok = (state_q == S_RUN) && (issued_q < count_q) && (|disp_elig) && !hit_block;
  assign col_ok  = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (n_done_q < issued_q) && (|col_elig);

  // Lowest-index free engine: descending scan leaves the lowest hit last.
  always_comb begin
    disp_idx = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (disp_elig[k]) disp_idx = PTR_W'(k);
    end
  end

  // Round-robin search starting one past the last acked unit.
  always_comb begin
    col_idx   = rr_ptr_q;
    col_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_UNITS; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_UNITS);
      if (!col_found && col_elig[cand]) begin
        col_found = 1'b1;
        col_idx   = cand;
      end
    end
  end

  always_comb begin
    col_e   = '0;
    col_seq = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (col_idx == PTR_W'(k)) begin
        col_e   = res_e[k*E_WIDTH +: E_WIDTH];
        col_seq = res_seq[k*SEQ_WIDTH +: SEQ_WIDTH];
      end
    end
  end

  // NOTE: every _d signal is given a default before any branch, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    issued_d    = issued_q;
    n_done_d    = n_done_q;
    best_e_d    = best_e_q;
    best_seq_d  = best_seq_q;
    eng_valid_d = '0;
    eng_seq_d   = eng_seq_q;
    res_ack_d   = '0;
    rr_ptr_d    = rr_ptr_q;
`ifdef CALC_E_SCHED_THRESH_EN
    thresh_d    = thresh_q;
    hit_d       = hit_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          count_d    = cfg_count;
          issued_d   = '0;
          n_done_d   = '0;
          best_e_d   = '1;
          best_seq_d = '0;
          rr_ptr_d   = PTR_W'(NUM_UNITS - 1);
`ifdef CALC_E_SCHED_THRESH_EN
          thresh_d   = cfg_thresh;
          hit_d      = 1'b0;
`endif
          state_d    = (cfg_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (issued_q == count_q) state_d = S_DRAIN;
      S_DRAIN: if (n_done_q == issued_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (s_valid && disp_ok) begin
      eng_valid_d = NUM_UNITS'(1) << disp_idx;
      eng_seq_d   = s_seq;
      issued_d    = issued_q + CNT_WIDTH'(1);
    end

    if (col_ok) begin
      res_ack_d = NUM_UNITS'(1) << col_idx;
      rr_ptr_d  = col_idx;
      n_done_d  = n_done_q + CNT_WIDTH'(1);
      // Strict compare: on a tie the earlier-retired result stays.
      if (col_e < best_e_q) begin
        best_e_d   = col_e;
        best_seq_d = col_seq;
      end
`ifdef CALC_E_SCHED_THRESH_EN
      if (col_e <= thresh_q) begin
        hit_d = 1'b1;
        if (state_q == S_RUN) state_d = S_DRAIN;
      end
`endif
    end
  end

  // NOTE: state registers take non-blocking assignments only; all decisions live in the always_comb above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      issued_q    <= '0;
      n_done_q    <= '0;
      best_e_q    <= '1;
      best_seq_q  <= '0;
      eng_valid_q <= '0;
      eng_seq_q   <= '0;
      res_ack_q   <= '0;
      rr_ptr_q    <= PTR_W'(NUM_UNITS - 1);
`ifdef CALC_E_SCHED_THRESH_EN
      thresh_q    <= '0;
      hit_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      n_done_q    <= n_done_d;
      best_e_q    <= best_e_d;
      best_seq_q  <= best_seq_d;
      eng_valid_q <= eng_valid_d;
      eng_seq_q   <= eng_seq_d;
      res_ack_q   <= res_ack_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef CALC_E_SCHED_THRESH_EN
      thresh_q    <= thresh_d;
      hit_q       <= hit_d;
`endif
    end
  end

  assign s_ready   = disp_ok;
  assign eng_valid = eng_valid_q;
  assign eng_seq   = eng_seq_q;
  assign res_ack   = res_ack_q;
  assign best_e    = best_e_q;
  assign best_seq  = best_seq_q;
  assign n_done    = n_done_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

endmodule
